// File: rtl/os_systolic_array_db.sv
// Output-stationary systolic matmul engine with a double-buffered result store.
// C = A*B for ROWS x K by K x COLS operands, one K-slice per input beat.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_valid/ready    beat handshake for a_data, b_data, len_i
//   len_i             K, sampled on the first beat of a job (0 acts as 1)
//   a_data            column k of A, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_data            row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/ready   result row handshake
//   out_last          marks row ROWS-1
//   out_data          one row of C, element j at [j*ACC_WIDTH +: ACC_WIDTH]
//   busy              array FSM not idle
//   signed_i          only with SIGNED_EN defined: two's-complement operands,
//                     sampled with len_i on the first beat
//
// Optional feature macro: SIGNED_EN (undefined = unsigned only, no signed_i).

module os_systolic_array_db #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LEN_WIDTH-1:0]       len_i,
`ifdef SIGNED_EN
  input  logic                       signed_i,
`endif
  input  logic [DATA_WIDTH*ROWS-1:0] a_data,
  input  logic [DATA_WIDTH*COLS-1:0] b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [ACC_WIDTH*COLS-1:0]  out_data,
  output logic                       busy
);

  localparam int PW  = 2*DATA_WIDTH;
  localparam int XW  = ACC_WIDTH-PW;
  localparam int DRN = ROWS+COLS-1;
  localparam int DCW = $clog2(DRN+1);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [DCW-1:0]       drn_q, drn_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 out_valid_q, out_valid_d;

  logic accept;
  logic en;
  logic clr;
  logic sgn_in;
  logic sgn_cur;
  logic sgn_mul;

  logic [DATA_WIDTH-1:0] a_in   [ROWS];
  logic [DATA_WIDTH-1:0] b_in   [COLS];
  logic [DATA_WIDTH-1:0] a_sk_q [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] a_sk_d [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] b_sk_q [COLS][COLS];
  logic [DATA_WIDTH-1:0] b_sk_d [COLS][COLS];
  logic [DATA_WIDTH-1:0] a_left [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_top  [ROWS][COLS];
  logic [DATA_WIDTH-1:0] a_q    [ROWS][COLS];
  logic [DATA_WIDTH-1:0] a_d    [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_q    [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_d    [ROWS][COLS];
  logic [PW-1:0]         p_q    [ROWS][COLS];
  logic [PW-1:0]         p_d    [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_q  [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_d  [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  obuf_q [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  obuf_d [ROWS][COLS];

  function automatic logic [PW-1:0] mul(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y,
    input logic                  s
  );
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = {{DATA_WIDTH{s & x[DATA_WIDTH-1]}}, x};
    ye = {{DATA_WIDTH{s & y[DATA_WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] ext(
    input logic [PW-1:0] p,
    input logic          s
  );
    return {{XW{s & p[PW-1]}}, p};
  endfunction

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept   = in_valid && in_ready;
  assign en       = accept || (state_q == S_DRAIN);
  // Results move to the output store only once it has fully drained.
  assign clr      = (state_q == S_HOLD) && !out_valid_q;
  assign busy     = (state_q != S_IDLE);

`ifdef SIGNED_EN
  logic sgn_q, sgn_d;
  assign sgn_in = signed_i;
  always_comb begin
    sgn_d = sgn_q;
    if (accept && (state_q == S_IDLE)) sgn_d = signed_i;
  end
  always_ff @(posedge clk) begin
    if (reset) sgn_q <= 1'b0;
    else       sgn_q <= sgn_d;
  end
  assign sgn_cur = sgn_q;
`else
  assign sgn_in  = 1'b0;
  assign sgn_cur = 1'b0;
`endif

  // The first beat's products form before the mode flop updates.
  assign sgn_mul = (state_q == S_IDLE) ? sgn_in : sgn_cur;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drn_d   = drn_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (len_i <= LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
            drn_d   = DCW'(DRN-1);
          end else begin
            state_d = S_LOAD;
            rem_d   = len_i - LEN_WIDTH'(1);
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
            drn_d   = DCW'(DRN-1);
          end else begin
            rem_d = rem_q - LEN_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) state_d = S_HOLD;
        else             drn_d   = drn_q - DCW'(1);
      end
      S_HOLD: begin
        if (!out_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Zero is fed in while draining so trailing products vanish.
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      a_in[i] = accept ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    for (int j = 0; j < COLS; j++)
      b_in[j] = accept ? b_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    a_sk_d = a_sk_q;
    b_sk_d = b_sk_q;
    if (clr) begin
      a_sk_d = '{default: '0};
      b_sk_d = '{default: '0};
    end else if (en) begin
      for (int i = 0; i < ROWS; i++) begin
        a_sk_d[i][0] = a_in[i];
        for (int k = 1; k < ROWS; k++)
          a_sk_d[i][k] = a_sk_q[i][k-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_sk_d[j][0] = b_in[j];
        for (int k = 1; k < COLS; k++)
          b_sk_d[j][k] = b_sk_q[j][k-1];
      end
    end
  end

  // Row i of A enters i enables late, column j of B j enables late.
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      a_left[i][0] = a_in[i];
    for (int i = 1; i < ROWS; i++)
      a_left[i][0] = a_sk_q[i][i-1];
    for (int i = 0; i < ROWS; i++)
      for (int j = 1; j < COLS; j++)
        a_left[i][j] = a_q[i][j-1];
    for (int j = 0; j < COLS; j++)
      b_top[0][j] = b_in[j];
    for (int j = 1; j < COLS; j++)
      b_top[0][j] = b_sk_q[j][j-1];
    for (int i = 1; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        b_top[i][j] = b_q[i-1][j];
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    p_d   = p_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '{default: '0};
      b_d   = '{default: '0};
      p_d   = '{default: '0};
      acc_d = '{default: '0};
    end else if (en) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_d[i][j]   = a_left[i][j];
          b_d[i][j]   = b_top[i][j];
          p_d[i][j]   = mul(a_left[i][j], b_top[i][j], sgn_mul);
          acc_d[i][j] = acc_q[i][j] + ext(p_q[i][j], sgn_cur);
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    row_d       = row_q;
    obuf_d      = obuf_q;
    unique case (1'b1)
      clr: begin
        out_valid_d = 1'b1;
        row_d       = '0;
        obuf_d      = acc_q;
      end
      (out_valid_q && out_ready): begin
        if (row_q == RW'(ROWS-1)) begin
          out_valid_d = 1'b0;
          row_d       = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      drn_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      a_sk_q      <= '{default: '0};
      b_sk_q      <= '{default: '0};
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      p_q         <= '{default: '0};
      acc_q       <= '{default: '0};
      obuf_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      drn_q       <= drn_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      a_sk_q      <= a_sk_d;
      b_sk_q      <= b_sk_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      obuf_q      <= obuf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (row_q == RW'(ROWS-1));

  always_comb begin
    out_data = '0;
    if (out_valid_q)
      for (int j = 0; j < COLS; j++)
        out_data[j*ACC_WIDTH +: ACC_WIDTH] = obuf_q[row_q][j];
  end

endmodule

// File: tb/tb_os_systolic_array_db.sv
// Bench for os_systolic_array_db on a 2x3 tile.
// Random and directed jobs checked against a plain dot-product model.

module tb_os_systolic_array_db;

  localparam int DW   = 8;
  localparam int R    = 2;
  localparam int C    = 3;
  localparam int LW   = 16;
  localparam int AW   = 2*DW+LW;
  localparam int OW   = AW*C;
  localparam int AIW  = DW*R;
  localparam int BIW  = DW*C;
  localparam int MAXK = 320;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [LW-1:0]  len_i     = '0;
  logic [AIW-1:0] a_data    = '0;
  logic [BIW-1:0] b_data    = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_last;
  logic [OW-1:0]  out_data;
  logic           busy;
`ifdef SIGNED_EN
  logic           sgn_drv   = 1'b0;
`endif

  int n_chk    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_acc = 0;
  int out_row  = 0;
  bit ok;

  logic [DW-1:0] a_mem [MAXK][R];
  logic [DW-1:0] b_mem [MAXK][C];
  logic [OW-1:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  os_systolic_array_db #(
    .DATA_WIDTH(DW),
    .ROWS(R),
    .COLS(C),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .len_i(len_i),
`ifdef SIGNED_EN
    .signed_i(sgn_drv),
`endif
    .a_data(a_data),
    .b_data(b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_data(out_data),
    .busy(busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [OW-1:0] obs,
                      input logic [OW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C[i][j] = sum_k A[k][i]*B[k][j], reduced modulo 2^AW.
  task automatic push_exp(input int k);
    logic [OW-1:0] row;
    longint s, av, bv;
    logic sg;
`ifdef SIGNED_EN
    sg = sgn_drv;
`else
    sg = 1'b0;
`endif
    for (int i = 0; i < R; i++) begin
      row = '0;
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int t = 0; t < k; t++) begin
          av = sg ? longint'($signed(a_mem[t][i])) : longint'(a_mem[t][i]);
          bv = sg ? longint'($signed(b_mem[t][j])) : longint'(b_mem[t][j]);
          s += av * bv;
        end
        row[j*AW +: AW] = AW'(s);
      end
      exp_q.push_back(row);
    end
  endtask

  // mode 0 random, 1 all 0xFF, 2 fixed small case, 3 a=0xFF b=2
  task automatic gen_job(input int k, input int mode, input bit push);
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i < R; i++)
        case (mode)
          0:       a_mem[t][i] = DW'($urandom);
          2:       a_mem[t][i] = DW'(2 + i);
          default: a_mem[t][i] = 8'hFF;
        endcase
      for (int j = 0; j < C; j++)
        case (mode)
          0:       b_mem[t][j] = DW'($urandom);
          1:       b_mem[t][j] = 8'hFF;
          2:       b_mem[t][j] = DW'(4 + j);
          default: b_mem[t][j] = 8'd2;
        endcase
    end
    if (push) push_exp(k);
  endtask

  task automatic drive_job(input int k, input bit gaps,
                           input int len_val, input int nbeats);
    bit hs;
    int tmo;
    for (int t = 0; t < nbeats; t++) begin
      in_valid = 1'b1;
      len_i    = (t == 0) ? LW'(len_val) : LW'($urandom);
      for (int i = 0; i < R; i++) a_data[i*DW +: DW] = a_mem[t][i];
      for (int j = 0; j < C; j++) b_data[j*DW +: DW] = b_mem[t][j];
      hs  = 1'b0;
      tmo = 0;
      do begin
        hs = in_ready;
        if (hs) last_acc = cyc;
        @(posedge clk);
        #1;
        tmo++;
      end while (!hs && tmo < 200);
      chk1("beat_accept", hs, 1'b1);
      in_valid = 1'b0;
      a_data   = AIW'($urandom);
      b_data   = BIW'($urandom);
      chk1("ready_after_beat", in_ready, (t < k-1));
      if (gaps && t < nbeats-1) begin
        @(posedge clk);
        #1;
        chk1("ready_in_gap", in_ready, 1'b1);
      end
    end
  endtask

  task automatic wait_out(output bit got);
    int tmo;
    tmo = 0;
    while (!out_valid && tmo < 2000) begin
      @(posedge clk);
      #1;
      tmo++;
    end
    got = out_valid;
  endtask

  task automatic collect(input int n, input bit bp);
    bit got;
    int tmo;
    logic [OW-1:0] e;
    for (int r = 0; r < n; r++) begin
      got = 1'b0;
      tmo = 0;
      while (!got && tmo < 2000) begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && exp_q.size() > 0) begin
          if (out_ready) begin
            e = exp_q.pop_front();
            chkd("row_data", out_data, e);
            chk1("row_last", out_last, (out_row == R-1));
            out_row = (out_row + 1) % R;
            got = 1'b1;
          end else begin
            chkd("stall_data", out_data, exp_q[0]);
          end
        end
        @(posedge clk);
        #1;
        tmo++;
      end
      chk1("row_seen", got, 1'b1);
    end
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkd("rst_out_data", out_data, '0);
    reset = 1'b0;
    exp_q.delete();
    out_row = 0;
  endtask

  initial begin
    do_reset(2);

    // 2x3 reference case with K=1 and output latency
    gen_job(1, 2, 1'b1);
    drive_job(1, 1'b0, 1, 1);
    wait_out(ok);
    chk1("small_valid", ok, 1'b1);
    chki("small_latency", cyc - last_acc, R+C+1);
    collect(R, 1'b0);

    // random job under output backpressure
    gen_job(5, 0, 1'b1);
    drive_job(5, 1'b0, 5, 5);
    collect(R, 1'b1);

    // bubbles every other cycle, then the same operands gap-free
    gen_job(4, 0, 1'b1);
    drive_job(4, 1'b1, 4, 4);
    push_exp(4);
    drive_job(4, 1'b0, 4, 4);
    collect(2*R, 1'b0);

    // len_i = 0 behaves as a single beat
    gen_job(1, 0, 1'b1);
    drive_job(1, 1'b0, 0, 1);
    collect(R, 1'b0);

    // saturated operands over a long K must not wrap
    gen_job(300, 1, 1'b1);
    drive_job(300, 1'b0, 300, 300);
    collect(R, 1'b0);

    // a=0xFF, b=2, K=3: signed -6 or unsigned 1530
`ifdef SIGNED_EN
    sgn_drv = 1'b1;
`endif
    gen_job(3, 3, 1'b1);
    drive_job(3, 1'b0, 3, 3);
    collect(R, 1'b0);
`ifdef SIGNED_EN
    sgn_drv = 1'b0;
`endif

    // job 2 parks behind a stalled job 1
    gen_job(3, 0, 1'b1);
    drive_job(3, 1'b0, 3, 3);
    wait_out(ok);
    chk1("job1_valid", ok, 1'b1);
    gen_job(2, 0, 1'b1);
    drive_job(2, 1'b0, 2, 2);
    repeat (R+C+3) begin
      @(posedge clk);
      #1;
    end
    chk1("parked_ready", in_ready, 1'b0);
    chk1("parked_busy", busy, 1'b1);
    chk1("held_valid", out_valid, 1'b1);
    chk1("held_last", out_last, 1'b0);
    chkd("held_row0", out_data, exp_q[0]);
    collect(2*R, 1'b1);

    // reset in the middle of loading
    gen_job(5, 0, 1'b0);
    drive_job(5, 1'b0, 5, 2);
    do_reset(1);
    gen_job(4, 0, 1'b1);
    drive_job(4, 1'b0, 4, 4);
    collect(R, 1'b1);

    // reset while a result is being presented
    gen_job(2, 0, 1'b1);
    drive_job(2, 1'b0, 2, 2);
    wait_out(ok);
    chk1("pre_reset_valid", ok, 1'b1);
    do_reset(1);
    gen_job(3, 0, 1'b1);
    drive_job(3, 1'b0, 3, 3);
    wait_out(ok);
    chk1("fresh_valid", ok, 1'b1);
    chki("fresh_latency", cyc - last_acc, R+C+1);
    collect(R, 1'b0);

    chki("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
